// File: rtl/rcosc_reset_sequencer.sv
// Power-up / recovery reset sequencer: init wait, oscillator settle, PLL lock wait, staggered domain release.
// Optional lock-timeout fault path enabled by defining RCOSC_SEQ_LOCK_TIMEOUT_EN.
module rcosc_reset_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int STARTUP_CYCLES = 1600,
    parameter int STAGGER_CYCLES = 160,
    parameter int LOCK_TIMEOUT   = 16000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   init_done_i,
    input  logic                   pll_lock_i,
    input  logic                   sw_rst_req_i,
    output logic                   clk_en_o,
    output logic [NUM_DOMAINS-1:0] domain_reset_n_o,
    output logic                   seq_done_o,
    output logic                   lock_fault_o,
    output logic [2:0]             state_o
);
    localparam int REL_CYCLES = NUM_DOMAINS * STAGGER_CYCLES;
    localparam int MAX_A      = (STARTUP_CYCLES > REL_CYCLES) ? STARTUP_CYCLES : REL_CYCLES;
    localparam int CNT_MAX    = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CW         = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_INIT = 3'd1,
        SETTLE    = 3'd2,
        WAIT_LOCK = 3'd3,
        RELEASE   = 3'd4,
        RUN       = 3'd5,
        FAULT     = 3'd6
    } state_e;

    logic [1:0]             init_sync_q, lock_sync_q;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    int                     cnt_v;
    logic                   restart;
    logic                   init_s, lock_s;
    logic                   clk_en_d, seq_done_d;
    logic [NUM_DOMAINS-1:0] dom_d;
`ifdef RCOSC_SEQ_LOCK_TIMEOUT_EN
    logic                   lf_q, lf_d;
`endif

    assign init_s = init_sync_q[1];
    assign lock_s = lock_sync_q[1];
    assign cnt_v  = int'(cnt_q);

    always_comb begin
        state_d = state_q;
        restart = 1'b0;
`ifdef RCOSC_SEQ_LOCK_TIMEOUT_EN
        lf_d    = lf_q;
`endif
        case (state_q)
            IDLE:      state_d = WAIT_INIT;
            WAIT_INIT: if (init_s) state_d = SETTLE;
            SETTLE:    if (cnt_v >= STARTUP_CYCLES - 1) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s) state_d = RELEASE;
`ifdef RCOSC_SEQ_LOCK_TIMEOUT_EN
                else if (cnt_v >= LOCK_TIMEOUT - 1) begin
                    state_d = FAULT;
                    lf_d    = 1'b1;
                end
`endif
            end
            RELEASE:   if (cnt_v >= REL_CYCLES) state_d = RUN;
            RUN:       state_d = RUN;
            FAULT:     if (lock_s) state_d = RELEASE;
            default:   state_d = IDLE;
        endcase
        // Aborts override normal flow; the software request outranks lock loss.
        if (!lock_s && (state_q == RELEASE || state_q == RUN)) state_d = WAIT_LOCK;
        if (sw_rst_req_i && state_q != IDLE && state_q != WAIT_INIT) begin
            state_d = SETTLE;
            restart = 1'b1;
`ifdef RCOSC_SEQ_LOCK_TIMEOUT_EN
            lf_d    = 1'b0;
`endif
        end
        if (restart || state_d != state_q) cnt_d = '0;
        else if (cnt_q == {CW{1'b1}})      cnt_d = cnt_q;
        else                               cnt_d = cnt_q + CW'(1);
    end

    // Outputs are a registered decode of the state, so they trail it by one cycle.
    always_comb begin
        clk_en_d   = (state_q == RELEASE) || (state_q == RUN);
        seq_done_d = (state_q == RUN) || (state_q == RELEASE && cnt_v >= REL_CYCLES);
        dom_d      = '0;
        for (int k = 0; k < NUM_DOMAINS; k++)
            dom_d[k] = (state_q == RUN) ||
                       (state_q == RELEASE && cnt_v >= (k + 1) * STAGGER_CYCLES);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_sync_q      <= '0;
            lock_sync_q      <= '0;
            state_q          <= IDLE;
            cnt_q            <= '0;
            clk_en_o         <= 1'b0;
            domain_reset_n_o <= '0;
            seq_done_o       <= 1'b0;
            state_o          <= 3'd0;
        end else begin
            init_sync_q      <= {init_sync_q[0], init_done_i};
            lock_sync_q      <= {lock_sync_q[0], pll_lock_i};
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            clk_en_o         <= clk_en_d;
            domain_reset_n_o <= dom_d;
            seq_done_o       <= seq_done_d;
            state_o          <= state_q;
        end
    end

`ifdef RCOSC_SEQ_LOCK_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lf_q         <= 1'b0;
            lock_fault_o <= 1'b0;
        end else begin
            lf_q         <= lf_d;
            lock_fault_o <= lf_q;
        end
    end
`else
    assign lock_fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_rcosc_reset_sequencer.sv
// Bench for rcosc_reset_sequencer: timestamp-based output model plus directed literal checks.
module tb_rcosc_reset_sequencer;
    localparam int ND = 4, SU = 8, ST = 4, LT = 32;

    logic          clk = 1'b0, rst = 1'b1, init = 1'b0, lock = 1'b0, sw = 1'b0;
    logic          clk_en, seq_done, lock_fault;
    logic [ND-1:0] dom;
    logic [2:0]    state;

    int checks = 0, errors = 0;

    rcosc_reset_sequencer #(
        .NUM_DOMAINS(ND), .STARTUP_CYCLES(SU), .STAGGER_CYCLES(ST), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .init_done_i(init), .pll_lock_i(lock), .sw_rst_req_i(sw),
        .clk_en_o(clk_en), .domain_reset_n_o(dom), .seq_done_o(seq_done),
        .lock_fault_o(lock_fault), .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model works in output time: ms is the state shown on STATE, me the edge it was entered.
    // Inputs reach the outputs 4 edges (init/lock) or 2 edges (sw) after being presented.
    int       ms = 0, me = 0, mcyc = 0, mage = 0;
    bit       mlf = 0;
    bit [3:0] hl = 0, hi = 0, hs = 0;
    int       md, mns;
    bit       mrs, mlk, min, msw;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            ms = 0; mage = 0; mlf = 0; hl = 0; hi = 0; hs = 0;
        end else begin
            mcyc++; mage++;
            hl = {hl[2:0], lock}; hi = {hi[2:0], init}; hs = {hs[2:0], sw};
            mlk = hl[3]; min = hi[3]; msw = hs[1];
            md = mcyc - me; mns = ms; mrs = 0;
            case (ms)
                0: if (mage >= 2) mns = 1;
                1: if (min) mns = 2;
                2: if (md >= SU) mns = 3;
                3: begin
                    if (mlk) mns = 4;
`ifdef RCOSC_SEQ_LOCK_TIMEOUT_EN
                    else if (md >= LT) begin mns = 6; mlf = 1; end
`endif
                end
                4: if (md > ND * ST) mns = 5;
                6: if (mlk) mns = 4;
                default: ;
            endcase
            if (!mlk && (ms == 4 || ms == 5)) mns = 3;
            if (msw && ms >= 2) begin mns = 2; mrs = 1; mlf = 0; end
            if (mns != ms || mrs) me = mcyc;
            ms = mns;
        end
    end

    int       ed;
    bit [3:0] edom;
    initial forever begin
        @(negedge clk);
        ed = mcyc - me;
        for (int k = 0; k < ND; k++)
            edom[k] = (ms == 5) || (ms == 4 && ed >= (k + 1) * ST);
        chk("model_state", state, ms);
        chk("model_clk_en", clk_en, (ms == 4 || ms == 5) ? 1 : 0);
        chk("model_domain_reset_n", dom, edom);
        chk("model_seq_done", seq_done, ((ms == 5) || (ms == 4 && ed >= ND * ST)) ? 1 : 0);
        chk("model_lock_fault", lock_fault, mlf);
    end

    task automatic wait_state(input int s, input int maxc);
        int n = 0;
        while (state != s && n < maxc) begin @(negedge clk); n++; end
        chk("wait_state", state, s);
    endtask

    task automatic wait_clk_en(input int maxc);
        int n = 0;
        while (!clk_en && n < maxc) begin @(negedge clk); n++; end
        chk("wait_clk_en", clk_en, 1);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_clk_en", clk_en, 0);
        chk("rst_dom", dom, 0);
        chk("rst_seq_done", seq_done, 0);
        chk("rst_lock_fault", lock_fault, 0);

        // Nominal power-up
        rst = 0; init = 1; lock = 1;
        wait_state(2, 20);
        n = 0;
        while (state == 2 && n < 50) begin @(negedge clk); n++; end
        chk("settle_len", n, SU);
        wait_clk_en(20);
        chk("release_state", state, 4);
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j == 3)  chk("dom_before_first", dom, 4'b0000);
            if (j == 4)  chk("dom_plus4", dom, 4'b0001);
            if (j == 8)  chk("dom_plus8", dom, 4'b0011);
            if (j == 12) chk("dom_plus12", dom, 4'b0111);
            if (j == 15) chk("seq_done_early", seq_done, 0);
            if (j == 16) begin
                chk("dom_plus16", dom, 4'b1111);
                chk("seq_done_plus16", seq_done, 1);
            end
        end
        @(negedge clk);
        chk("run_state", state, 5);

        // Lock loss in RUN, 10 cycles
        lock = 0;
        repeat (3) @(negedge clk);
        chk("lockloss_hold", dom, 4'b1111);
        @(negedge clk);
        chk("lockloss_dom", dom, 4'b0000);
        chk("lockloss_clk_en", clk_en, 0);
        chk("lockloss_state", state, 3);
        repeat (6) @(negedge clk);
        lock = 1;
        wait_clk_en(20);

        // Software request mid-RELEASE together with a lock drop
        repeat (6) @(negedge clk);
        sw = 1; lock = 0;
        @(negedge clk);
        sw = 0; lock = 1;
        @(negedge clk);
        chk("sw_dom", dom, 4'b0000);
        chk("sw_state", state, 2);
        wait_state(5, 100);

`ifdef RCOSC_SEQ_LOCK_TIMEOUT_EN
        lock = 0;
        wait_state(6, 100);
        chk("timeout_fault", lock_fault, 1);
        lock = 1;
        wait_state(5, 100);
        chk("fault_sticky", lock_fault, 1);
        sw = 1;
        @(negedge clk);
        sw = 0;
        @(negedge clk);
        chk("fault_cleared", lock_fault, 0);
        chk("fault_sw_state", state, 2);
        wait_state(5, 100);
`else
        lock = 0;
        wait_state(3, 20);
        repeat (1000) @(negedge clk);
        chk("no_timeout_state", state, 3);
        chk("no_timeout_fault", lock_fault, 0);
        lock = 1;
        wait_state(5, 100);
`endif

        // Asynchronous reset in RUN, between edges
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("async_state", state, 0);
        chk("async_clk_en", clk_en, 0);
        chk("async_dom", dom, 0);
        chk("async_seq_done", seq_done, 0);
        chk("async_lock_fault", lock_fault, 0);
        init = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (10) @(negedge clk);
        chk("wait_init_hold", state, 1);
        init = 1;
        wait_state(5, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
